// File: rtl/shift_step_pkg.sv
// Shared types and operation codes for the shift register front-end and its
// downstream shift register block.
package shift_step_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    FIRE     = 3'd2,
    HOLD     = 3'd3,
    REPEAT   = 3'd4,
    WAIT_REL = 3'd5
  } state_e;

  localparam logic [2:0] OP_CLR  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_LSR  = 3'd2;
  localparam logic [2:0] OP_LSL  = 3'd3;
  localparam logic [2:0] OP_ASR  = 3'd4;
  localparam logic [2:0] OP_SIN  = 3'd5;
  localparam logic [2:0] OP_ROR  = 3'd6;
  localparam logic [2:0] OP_ROL  = 3'd7;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stability counter: db follows the
// synchronised button only after DEBOUNCE_CYCLES consecutive differing samples.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 25
) (
  input  logic clk,
  input  logic clrn,
  input  logic btn_raw,
  output logic db
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_reg;
  logic             db_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             s;

  assign s  = sync_reg[1];
  assign db = db_reg;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], btn_raw};
    end
  end

  // Any sample agreeing with db restarts the count, so short glitches never land.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      db_reg  <= 1'b0;
      cnt_reg <= '0;
    end else if (s == db_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == DB_LAST) begin
      db_reg  <= s;
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/shift_step_ctrl.sv
// Button-driven step generator: latches op code/data on each press and emits
// one-cycle step pulses, with optional auto-repeat while the button is held.
module shift_step_ctrl
  import shift_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CNT_W           = 25
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       btn_raw,
  input  logic       auto_en,
  input  logic [2:0] sw_ctrl,
  input  logic [7:0] sw_data,
  output logic       step,
  output logic [2:0] ctrl_out,
  output logic [7:0] data_out,
  output logic [7:0] step_cnt
);

  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic             db;
  state_e           state_reg, state_next;
  logic [CNT_W-1:0] timer_reg, timer_next;
  logic             first_reg;
  logic [2:0]       ctrl_reg;
  logic [7:0]       data_reg;
  logic [7:0]       cnt_reg;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debounce (
    .clk    (clk),
    .clrn   (clrn),
    .btn_raw(btn_raw),
    .db     (db)
  );

  // Release is tested first everywhere so it beats both timer expiry and auto_en.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (db) state_next = LOAD;
      LOAD:     state_next = FIRE;
      FIRE: begin
        if (!db)                       state_next = IDLE;
        else if (auto_en && first_reg) state_next = HOLD;
        else if (auto_en)              state_next = REPEAT;
        else                           state_next = WAIT_REL;
      end
      HOLD: begin
        if (!db)                          state_next = IDLE;
        else if (!auto_en)                state_next = WAIT_REL;
        else if (timer_reg == DELAY_LAST) state_next = FIRE;
      end
      REPEAT: begin
        if (!db)                           state_next = IDLE;
        else if (!auto_en)                 state_next = WAIT_REL;
        else if (timer_reg == PERIOD_LAST) state_next = FIRE;
      end
      WAIT_REL: if (!db) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    timer_next = '0;
    if (state_next == state_reg && (state_reg == HOLD || state_reg == REPEAT)) begin
      timer_next = timer_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_reg <= IDLE;
      timer_reg <= '0;
      first_reg <= 1'b0;
      ctrl_reg  <= 3'd0;
      data_reg  <= 8'd0;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      // first_reg marks the FIRE that directly follows a press, selecting HOLD over REPEAT.
      if (state_reg == LOAD) begin
        ctrl_reg  <= sw_ctrl;
        data_reg  <= sw_data;
        first_reg <= 1'b1;
      end
      if (state_reg == FIRE) begin
        first_reg <= 1'b0;
        cnt_reg   <= cnt_reg + 8'd1;
      end
    end
  end

  assign step     = (state_reg == FIRE);
  assign ctrl_out = ctrl_reg;
  assign data_out = data_reg;
  assign step_cnt = cnt_reg;

endmodule

// File: doc/shift_step_ctrl.md
Name: shift_step_ctrl

Overview:
- Front-end stage that drives the 8-bit shift register's operation inputs from board controls.
- Synchronises and debounces the mechanical step button.
- Captures the 3-bit operation code and 8-bit data from switches at each press, then issues a clean one-cycle step pulse that the shift register uses as its clock enable.
- Optional auto-repeat while the button is held, and a running count of issued steps.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronised samples required to accept a level change (≥1).
- REPEAT_DELAY, 25000000, cycles in HOLD before the first auto-repeat step (≥1).
- REPEAT_PERIOD, 5000000, cycles in REPEAT between subsequent auto-repeat steps (≥1).
- CNT_W, 25, timer width; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- clk  in  1  system clock, all state on rising edge.
- clrn  in  1  reset, asynchronous, active-low.
- btn_raw  in  1  raw step button, active-high, asynchronous, bouncy.
- auto_en  in  1  auto-repeat enable (switch, quasi-static).
- sw_ctrl  in  3  operation code: 0 clear, 1 load, 2 lsr, 3 lsl, 4 asr, 5 serial-in, 6 ror, 7 rol.
- sw_data  in  8  load / serial data.
- step  out  1  one-cycle step pulse to the shift register.
- ctrl_out  out  3  latched operation code, stable while step is high.
- data_out  out  8  latched data, stable while step is high.
- step_cnt  out  8  number of steps issued, mod 256.

Behaviour:
- Reset:
  - Asynchronous on clrn=0, all flops cleared.
  - step=0, ctrl_out=0, data_out=0, step_cnt=0.
  - Sync flops=0, debounced level db=0, timers=0, state IDLE.
  - Reset mid-operation aborts immediately. No step is issued until a fresh press after release of clrn.
- Synchroniser:
  - Two flops on btn_raw produce s.
  - btn_raw is also routed through the same two-flop synchroniser.
- Debounce:
  - When s==db, the counter clears.
  - When s!=db, the counter increments.
  - When s!=db and the counter equals DEBOUNCE_CYCLES-1, db<=s and the counter clears.
  - Any return of s to db before that point restarts the count. Pulses shorter than DEBOUNCE_CYCLES never reach db.
- FSM states, checked in this priority order on each rising edge:
  - IDLE: if db=1, go to LOAD.
  - LOAD: ctrl_out<=sw_ctrl, data_out<=sw_data; go to FIRE.
  - FIRE: step=1 for exactly this cycle; step_cnt<=step_cnt+1, wrapping 255->0. Next state:
    - db=0: go to IDLE.
    - auto_en=1 and this is the first step of the press: go to HOLD.
    - auto_en=1 otherwise: go to REPEAT.
    - else: go to WAIT_REL.
  - HOLD: timer counts. Transitions:
    - db=0: go to IDLE.
    - auto_en=0: go to WAIT_REL.
    - timer reaches REPEAT_DELAY-1: go to FIRE.
  - REPEAT: same as HOLD, using REPEAT_PERIOD.
  - WAIT_REL: if db=0, go to IDLE.
- Timer clears on every state entry.
- step is decoded from the registered state (FIRE), so it is glitch-free.
- Timing:
  - First step is asserted DEBOUNCE_CYCLES+4 rising edges after the first edge that samples btn_raw=1, with btn_raw held stable.
  - First to second step: REPEAT_DELAY+1 cycles. Later steps: REPEAT_PERIOD+1 cycles apart.
- ctrl_out/data_out:
  - Change only in LOAD, one cycle before step.
  - Repeats reuse the values latched at the press; switch changes while held are ignored.
- Simultaneous events: release (db=0) wins over timer expiry and over auto_en. The step in a FIRE cycle always completes once entered.
- auto_en is not synchronised; it must be quasi-static. A change is honoured at the next HOLD/REPEAT/FIRE decision.

Decomposition:
- Package shift_step_pkg holds:
  - State enum: IDLE, LOAD, FIRE, HOLD, REPEAT, WAIT_REL.
  - Operation-code constants OP_CLR..OP_ROL (0..7), shared with the shift register block and its bench.
- One sub-module, btn_debounce (synchroniser plus debounce counter, params DEBOUNCE_CYCLES and CNT_W, output db).

Test Plan (sim params DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3):
1. Single press: sw_ctrl=1, sw_data=8'hA5, auto_en=0, btn_raw high 20 cycles then low -> exactly one step, 8 edges after first sampled high. ctrl_out=1, data_out=8'hA5 during step; step_cnt=1.
2. Bounce: btn_raw high 3 cycles / low 2 cycles, repeated 10 times -> db stays 0, no step, step_cnt=0.
3. Auto-repeat: auto_en=1, sw_ctrl=6, hold 40 cycles -> steps at t0, t0+11, t0+15, t0+19, ... while held. After release propagates, no further steps; step_cnt equals pulses counted.
4. Latch hold: auto_en=1, sw_ctrl=2 at press, changed to 3 during HOLD -> all repeat steps show ctrl_out=2. Next press shows ctrl_out=3.
5. auto_en dropped in REPEAT -> no more steps while held. After release and a new press, exactly one step (auto_en=0).
6. Reset/wrap:
   - 256 single presses -> step_cnt returns to 0.
   - clrn=0 asserted during REPEAT -> step, ctrl_out, data_out, step_cnt all 0 immediately (before the next clk edge).
   - Holding btn_raw through reset release -> step only after the debounce latency.
